// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, frame constants
// and the baud divider calculation.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;
  localparam int unsigned STOP_BITS = 1;

  typedef enum logic [2:0] {
    ST_WAIT_IDLE = 3'd0,
    ST_IDLE      = 3'd1,
    ST_START     = 3'd2,
    ST_DATA      = 3'd3,
    ST_STOP      = 3'd4
  } uart_state_t;

  // System clocks per bit period.
  function automatic int unsigned wait_count(input int unsigned clk_freq_mhz,
                                             input int unsigned baud_rate);
    return (clk_freq_mhz * 32'd1000000) / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for one asynchronous bit; both flops reset to RST_VAL.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta <= RST_VAL;
      q_o  <= RST_VAL;
    end else begin
      meta <= d_i;
      q_o  <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ready output, framing-error pulse and sticky overrun.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around each sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = 100,
  parameter int unsigned BAUD_RATE    = 921600
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 rxd_i,
  output logic                 rvalid_o,
  input  logic                 rready_i,
  output logic [DATA_BITS-1:0] rdata_o,
  output logic                 frame_err_o,
  output logic                 overrun_o
);

  localparam int unsigned WAIT_COUNT = wait_count(CLK_FREQ_MHZ, BAUD_RATE);
  localparam int unsigned HALF_COUNT = WAIT_COUNT / 2;
  localparam int unsigned CW         = $clog2(WAIT_COUNT);
  localparam int unsigned BW         = $clog2(DATA_BITS);

  logic                 rxd_s;
  logic                 sample_c;
  uart_state_t          state;
  logic [CW-1:0]        wait_cntr;
  logic [BW-1:0]        bit_cntr;
  logic [DATA_BITS-1:0] shift_reg;
  logic [1:0]           sync_fill;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (rxd_i),
    .q_o   (rxd_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] early_q;

  // Capture the two samples preceding each sample point.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      early_q <= 2'b11;
    end else begin
      if (wait_cntr == CW'(2)) early_q[1] <= rxd_s;
      if (wait_cntr == CW'(1)) early_q[0] <= rxd_s;
    end
  end

  assign sample_c = (early_q[1] & early_q[0]) | (early_q[1] & rxd_s) | (early_q[0] & rxd_s);
`else
  assign sample_c = rxd_s;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_WAIT_IDLE;
      wait_cntr   <= '0;
      bit_cntr    <= '0;
      shift_reg   <= '0;
      sync_fill   <= '0;
      rvalid_o    <= 1'b0;
      rdata_o     <= '0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= 1'b0;
      if (sync_fill != 2'd2) sync_fill <= sync_fill + 2'd1;
      if (rvalid_o && rready_i) rvalid_o <= 1'b0;

      case (state)
        // Synchronizer reset levels are not line samples, so they cannot re-arm.
        ST_WAIT_IDLE: begin
          if (rxd_s && sync_fill == 2'd2) state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (!rxd_s) begin
            state     <= ST_START;
            wait_cntr <= CW'(HALF_COUNT - 1);
          end
        end
        ST_START: begin
          if (wait_cntr != '0) begin
            wait_cntr <= wait_cntr - CW'(1);
          end else if (!sample_c) begin
            state     <= ST_DATA;
            wait_cntr <= CW'(WAIT_COUNT - 1);
            bit_cntr  <= BW'(DATA_BITS - 1);
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_DATA: begin
          if (wait_cntr != '0) begin
            wait_cntr <= wait_cntr - CW'(1);
          end else begin
            shift_reg <= {sample_c, shift_reg[DATA_BITS-1:1]};
            wait_cntr <= CW'(WAIT_COUNT - 1);
            if (bit_cntr == '0) state <= ST_STOP;
            else bit_cntr <= bit_cntr - BW'(1);
          end
        end
        ST_STOP: begin
          if (wait_cntr != '0) begin
            wait_cntr <= wait_cntr - CW'(1);
          end else if (sample_c) begin
            // Returning mid stop bit leaves room for a back-to-back start edge.
            state <= ST_IDLE;
            if (!rvalid_o || rready_i) begin
              rdata_o  <= shift_reg;
              rvalid_o <= 1'b1;
            end else begin
              overrun_o <= 1'b1;
            end
          end else begin
            frame_err_o <= 1'b1;
            state       <= ST_WAIT_IDLE;
          end
        end
        default: state <= ST_WAIT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized self-checking bench for uart_rx against a frame-level reference model.
module tb_uart_rx;

  localparam int unsigned CLK_MHZ = 100;
  localparam int unsigned BAUD    = 921600;
  localparam int unsigned BIT_CYC = (CLK_MHZ * 1000000) / BAUD;
  localparam int unsigned LATENCY = 2 + BIT_CYC / 2 + 9 * BIT_CYC;

  logic       clk_i    = 1'b0;
  logic       rst_i    = 1'b1;
  logic       rxd_i    = 1'b1;
  logic       rready_i = 1'b0;
  logic       rvalid_o;
  logic [7:0] rdata_o;
  logic       frame_err_o;
  logic       overrun_o;

  uart_rx #(.CLK_FREQ_MHZ(CLK_MHZ), .BAUD_RATE(BAUD)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .rxd_i       (rxd_i),
    .rvalid_o    (rvalid_o),
    .rready_i    (rready_i),
    .rdata_o     (rdata_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Consumer: either a fixed level or a random accept pattern.
  bit rready_rand = 1'b0;
  bit rready_cmd  = 1'b0;
  always @(posedge clk_i) begin
    #1;
    rready_i = rready_rand ? 1'($urandom_range(0, 1)) : rready_cmd;
  end

  // Observation of the output interface, sampled on the falling edge.
  logic [7:0]  got_q[$];
  logic [7:0]  exp_q[$];
  int unsigned rise_q[$];
  int          valid_cyc = 0;
  int          ferr_cyc  = 0;
  int          stab_err  = 0;
  logic        rvalid_d  = 1'b0;
  logic        hs_d      = 1'b0;
  logic [7:0]  rdata_d   = 8'h00;

  always @(negedge clk_i) begin
    if (rvalid_o && rready_i) got_q.push_back(rdata_o);
    if (rvalid_o && !rvalid_d) rise_q.push_back(cyc);
    if (rvalid_o) valid_cyc++;
    if (frame_err_o) ferr_cyc++;
    if (rvalid_d && !hs_d && rvalid_o && rdata_o != rdata_d) stab_err++;
    rvalid_d = rvalid_o;
    hs_d     = rvalid_o && rready_i;
    rdata_d  = rdata_o;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check(tag, (i < got_q.size()) ? 32'(got_q[i]) : 32'hDEAD, 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic idle_bits(input int n);
    rxd_i = 1'b1;
    if (n > 0) begin
      repeat (n * BIT_CYC) @(posedge clk_i);
      #1;
    end
  endtask

  // Caller is positioned just after a rising edge; the next edge is the start edge.
  task automatic send_frame(input logic [7:0] b, input logic stop, output int unsigned start);
    logic [9:0] bits;
    bits  = {stop, b, 1'b0};
    start = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      rxd_i = bits[i];
      repeat (BIT_CYC) @(posedge clk_i);
      #1;
    end
  endtask

`ifdef UART_RX_MAJORITY_EN
  // 0x00 with a one-cycle high spike landing on each data-bit sample point.
  task automatic send_spiky_zero();
    rxd_i = 1'b0;
    repeat (BIT_CYC) @(posedge clk_i);
    #1;
    for (int i = 0; i < 8; i++) begin
      rxd_i = 1'b0;
      repeat (BIT_CYC / 2) @(posedge clk_i);
      #1;
      rxd_i = 1'b1;
      @(posedge clk_i);
      #1;
      rxd_i = 1'b0;
      repeat (BIT_CYC - BIT_CYC / 2 - 1) @(posedge clk_i);
      #1;
    end
    idle_bits(1);
  endtask
`endif

  initial begin
    int unsigned t0;
    int          v0;
    int          f0;
    logic [7:0]  b;

    repeat (3) @(posedge clk_i);
    #1;
    check("rst_rvalid", rvalid_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_ferr", frame_err_o, 0);
    check("rst_ovr", overrun_o, 0);
    rst_i = 1'b0;
    idle_bits(2);

    // Single frame: exact latency and a one-cycle valid.
    rready_cmd = 1'b1;
    idle_bits(1);
    v0 = valid_cyc;
    rise_q.delete();
    send_frame(8'h55, 1'b1, t0);
    exp_q.push_back(8'h55);
    idle_bits(1);
    check("a_rises", rise_q.size(), 1);
    if (rise_q.size() > 0) check("a_latency", rise_q[0] - t0, LATENCY);
    check("a_valid_width", valid_cyc - v0, 1);
    check_bytes("a_data");

    // Back-to-back frames.
    f0 = ferr_cyc;
    send_frame(8'hA5, 1'b1, t0);
    send_frame(8'h3C, 1'b1, t0);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);
    idle_bits(1);
    check_bytes("b2b");
    check("b2b_ferr", ferr_cyc - f0, 0);
    check("b2b_ovr", overrun_o, 0);

    // Bad stop bit, long break, then a clean frame.
    f0 = ferr_cyc;
    rise_q.delete();
    send_frame(8'h7E, 1'b0, t0);
    rxd_i = 1'b0;
    repeat (20 * BIT_CYC) @(posedge clk_i);
    #1;
    check("brk_ferr", ferr_cyc - f0, 1);
    check("brk_no_valid", rise_q.size(), 0);
    idle_bits(2);
    send_frame(8'h42, 1'b1, t0);
    exp_q.push_back(8'h42);
    idle_bits(1);
    check_bytes("brk_after");
    check("brk_ferr_total", ferr_cyc - f0, 1);

    // Short low glitch on an idle line.
    f0 = ferr_cyc;
    rise_q.delete();
    rxd_i = 1'b0;
    repeat (20) @(posedge clk_i);
    #1;
    idle_bits(2);
    check("glitch_rises", rise_q.size(), 0);
    check("glitch_ferr", ferr_cyc - f0, 0);
    check_bytes("glitch");

`ifdef UART_RX_MAJORITY_EN
    send_spiky_zero();
    exp_q.push_back(8'h00);
    idle_bits(1);
    check_bytes("spike");
`endif

    // Random bytes, random gaps, random consumer.
    rready_rand = 1'b1;
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      idle_bits($urandom_range(0, 2));
      send_frame(b, 1'b1, t0);
      exp_q.push_back(b);
    end
    idle_bits(2);
    rready_cmd  = 1'b1;
    rready_rand = 1'b0;
    idle_bits(1);
    check_bytes("rand");
    check("rand_ovr", overrun_o, 0);

    // Overrun with a stalled consumer.
    rready_cmd = 1'b0;
    idle_bits(1);
    send_frame(8'h11, 1'b1, t0);
    idle_bits(1);
    check("ovr_first", overrun_o, 0);
    check("ovr_valid1", rvalid_o, 1);
    send_frame(8'h22, 1'b1, t0);
    idle_bits(1);
    check("ovr_hold_data", rdata_o, 8'h11);
    check("ovr_hold_valid", rvalid_o, 1);
    check("ovr_set", overrun_o, 1);
    check("ovr_no_xfer", got_q.size(), 0);
    rready_cmd = 1'b1;
    idle_bits(1);
    exp_q.push_back(8'h11);
    check_bytes("ovr_drain");
    check("ovr_valid_clr", rvalid_o, 0);
    check("ovr_sticky", overrun_o, 1);

    // Reset in the middle of data bit 4 while the line is low.
    rready_cmd = 1'b0;
    idle_bits(1);
    send_frame(8'h99, 1'b1, t0);
    check("pre_rst_valid", rvalid_o, 1);
    rise_q.delete();
    fork
      send_frame(8'hC3, 1'b1, t0);
      begin
        repeat (5 * BIT_CYC + 50) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        check("mid_rst_rxd_low", rxd_i, 0);
        check("mid_rst_rvalid", rvalid_o, 0);
        check("mid_rst_rdata", rdata_o, 0);
        check("mid_rst_ovr", overrun_o, 0);
        rst_i = 1'b0;
      end
    join
    f0 = ferr_cyc;
    rready_cmd = 1'b1;
    idle_bits(2);
    check("post_rst_rises", rise_q.size(), 0);
    check("post_rst_ferr", ferr_cyc - f0, 0);
    check_bytes("post_rst_quiet");
    send_frame(8'h5A, 1'b1, t0);
    exp_q.push_back(8'h5A);
    idle_bits(1);
    check_bytes("post_rst_data");
    check("post_rst_ovr", overrun_o, 0);

    check("rdata_stable", stab_err, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
